// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter that feeds one UART transmitter and guards against a transmitter that never goes busy.
// Define UART_ARB_FIXED_PRI_EN to use fixed priority (requester 0 always wins) instead of round-robin.
module uart_tx_arbiter #(
  parameter int unsigned STALL_LIMIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic [1:0] ack,
  output logic [1:0] grant,
  output logic       err,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] SEND      = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  localparam logic [7:0] STALL_LAST = 8'(STALL_LIMIT - 1);

  logic [2:0] state;
  logic [7:0] stall_cnt;
  logic       winner;
  logic       abort;

`ifdef UART_ARB_FIXED_PRI_EN
  always_comb winner = ~req[0];
`else
  logic rr;

  always_comb begin
    if (req == 2'b11) winner = rr;
    else              winner = req[1];
  end

  // Point at the requester that was not served so a persistent contender gets the next turn.
  always_ff @(posedge clk) begin
    if (reset)                        rr <= 1'b0;
    else if (state == DONE || abort)  rr <= grant[0];
  end
`endif

  // The counter holds cycles already spent in WAIT_BUSY, so the last allowed cycle sees STALL_LIMIT-1.
  always_comb abort = (state == WAIT_BUSY) && !tx_busy && (stall_cnt >= STALL_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= 2'b00;
      tx_data   <= 8'h00;
      stall_cnt <= 8'h00;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            grant   <= winner ? 2'b10 : 2'b01;
            tx_data <= winner ? data1 : data0;
            state   <= START;
          end
        end
        START: begin
          stall_cnt <= 8'h00;
          state     <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= SEND;
          end else if (abort) begin
            err   <= 1'b1;
            grant <= 2'b00;
            state <= IDLE;
          end else if (stall_cnt != 8'hFF) begin
            stall_cnt <= stall_cnt + 8'd1;
          end
        end
        SEND: begin
          if (!tx_busy) state <= DONE;
        end
        DONE: begin
          grant <= 2'b00;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    tx_start = (state == START);
    ack      = (state == DONE) ? grant : 2'b00;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: STALL_LIMIT, 16, max cycles to wait for tx_busy to rise after tx_start before aborting (range 2..255).
REQ-002 Port: clk  input  1  single system clock, all logic on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req  input  2  per-requester transmit request; bit i held high with data_i stable until ack[i] or err.
REQ-005 Port: data0  input  8  byte from requester 0.
REQ-006 Port: data1  input  8  byte from requester 1.
REQ-007 Port: ack  output  2  one-cycle pulse on bit i when requester i's byte has finished transmitting.
REQ-008 Port: grant  output  2  one-hot owner of the transmitter; 00 when idle.
REQ-009 Port: err  output  1  one-cycle pulse when a transfer aborts on stall timeout.
REQ-010 Port: tx_start  output  1  one-cycle start strobe to the UART transmitter.
REQ-011 Port: tx_data  output  8  byte presented to the transmitter, latched at grant.
REQ-012 Port: tx_busy  input  1  transmitter busy; high for the whole frame.

Function
REQ-013 The FSM SHALL have states IDLE, START, WAIT_BUSY, SEND, DONE.
REQ-014 IDLE: if any req bit is high at a clock edge, select a winner, latch its data into tx_data, set grant and go to START; otherwise stay.
REQ-015 Arbitration SHALL be round-robin: pointer rr (reset 0) names the preferred requester; a lone requester wins regardless of rr.
REQ-016 On DONE or abort, rr SHALL be set to the non-served requester.
REQ-017 START SHALL last exactly one cycle with tx_start=1, then go to WAIT_BUSY; tx_start SHALL be 0 in every other state.
REQ-018 Latency: req rising in IDLE at edge k SHALL yield tx_start high for the cycle after edge k+1.
REQ-019 WAIT_BUSY: go to SEND when tx_busy=1; a counter SHALL count cycles spent, and after STALL_LIMIT cycles without tx_busy SHALL pulse err for one cycle, clear grant and return to IDLE with no ack.
REQ-020 SEND: remain while tx_busy=1; on tx_busy=0 go to DONE.
REQ-021 DONE: pulse ack for the granted requester for one cycle, clear grant, update rr, return to IDLE.
REQ-022 tx_data and grant SHALL stay constant from IDLE exit until DONE or abort, regardless of changes on req or data inputs.
REQ-023 A req bit dropped after grant SHALL NOT cancel the transfer; ack still pulses.
REQ-024 A req bit still high in the cycle after its ack SHALL be treated as a new request (back-to-back allowed, no idle gap beyond IDLE's one cycle).
REQ-025 ack and err SHALL never be high in the same cycle, and at most one ack bit SHALL be high.
REQ-026 The stall counter SHALL saturate and clear on entry to WAIT_BUSY; it SHALL be wide enough for 255 without wrap.

Reset
REQ-027 With reset high at a clock edge: state=IDLE, rr=0, grant=00, ack=00, err=0, tx_start=0, tx_data=8'h00, stall counter=0.
REQ-028 Reset asserted mid-transfer SHALL abort silently, with no ack or err pulse.
REQ-029 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-030 Macro UART_ARB_FIXED_PRI_EN: when defined, arbitration SHALL be fixed priority, with requester 0 always winning and rr unused. When undefined, REQ-015/016 round-robin applies.

Verification
REQ-031 Single request: req=01, data0=8'hA5, model tx_busy high 3 cycles after start for 10 cycles -> tx_start once, tx_data=A5, grant=01, ack=01 pulse once, err=0.
REQ-032 Contention: req=11 held, data0=8'h11, data1=8'h22 -> sequence 11, 22, 11, 22 on tx_data with alternating acks; with UART_ARB_FIXED_PRI_EN the sequence is all 11.
REQ-033 Stall: req=10, tx_busy held 0 -> err pulse exactly STALL_LIMIT cycles after entering WAIT_BUSY, no ack, grant returns 00, next grant goes to requester 0 if it is requesting.
REQ-034 Data change mid-transfer: change data0 from 8'h3C to 8'hFF and drop req during SEND -> tx_data stays 3C, ack=01 still pulses.
REQ-035 Reset during SEND -> next cycle all outputs at reset values, no ack or err; a subsequent req=01 is served normally.
REQ-036 Back-to-back: req=01 held through ack -> second tx_start occurs 2 cycles after the ack pulse.
